// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register path: MIPS opcode constants,
// instruction class encoding and the bit positions of every instruction field.
package ir_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        CLASS_R = 2'd0,
        CLASS_I = 2'd1,
        CLASS_J = 2'd2
    } instr_class_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JT_MSB     = 25;
    localparam int JT_LSB     = 0;

    function automatic instr_class_t classify(input logic [5:0] opcode);
        instr_class_t cls;
        if (opcode == OP_RTYPE) begin
            cls = CLASS_R;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            cls = CLASS_J;
        end else begin
            cls = CLASS_I;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational MIPS field splitter; every output reads zero (a NOP) while the
// valid bit is low so downstream stages never see stale storage.
module ir_field_decode
    import ir_pkg::*;
(
    input  logic         valid,
    input  logic [31:0]  word,
    output logic [31:0]  instruction_word,
    output logic [5:0]   instruction_opcode,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic [4:0]   rd,
    output logic [4:0]   shamt,
    output logic [5:0]   func_code,
    output logic [15:0]  alu_immediate,
    output logic [31:0]  imm_sext,
    output logic [25:0]  jump_target,
    output instr_class_t instr_class
);

    logic [31:0] w;

    assign w = valid ? word : 32'd0;

    assign instruction_word   = w;
    assign instruction_opcode = w[OPCODE_MSB:OPCODE_LSB];
    assign rs                 = w[RS_MSB:RS_LSB];
    assign rt                 = w[RT_MSB:RT_LSB];
    assign rd                 = w[RD_MSB:RD_LSB];
    assign shamt              = w[SHAMT_MSB:SHAMT_LSB];
    assign func_code          = w[FUNC_MSB:FUNC_LSB];
    assign alu_immediate      = w[IMM_MSB:IMM_LSB];
    assign imm_sext           = {{16{w[IMM_MSB]}}, w[IMM_MSB:IMM_LSB]};
    assign jump_target        = w[JT_MSB:JT_LSB];
    // A zeroed word has opcode 0, so the invalid case naturally reports CLASS_R (0).
    assign instr_class        = classify(w[OPCODE_MSB:OPCODE_LSB]);

endmodule

// File: rtl/ir_fetch_queue.sv
// Instruction register FIFO between bus fetch and decode: buffers DEPTH words
// with their PCs and presents the head entry pre-split into MIPS fields.
module ir_fetch_queue
    import ir_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       instruction_word,
    output logic [5:0]        instruction_opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        func_code,
    output logic [15:0]       alu_immediate,
    output logic [31:0]       imm_sext,
    output logic [25:0]       jump_target,
    output logic [1:0]        instr_class,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid is never withdrawn by the queue, and ready does not depend on valid.
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    instr_class_t      head_class;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never cleared; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;

    ir_field_decode u_decode (
        .valid              (out_valid),
        .word               (instr_mem[rd_ptr]),
        .instruction_word   (instruction_word),
        .instruction_opcode (instruction_opcode),
        .rs                 (rs),
        .rt                 (rt),
        .rd                 (rd),
        .shamt              (shamt),
        .func_code          (func_code),
        .alu_immediate      (alu_immediate),
        .imm_sext           (imm_sext),
        .jump_target        (jump_target),
        .instr_class        (head_class)
    );

    assign instr_class = head_class;

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed bench for ir_fetch_queue at DEPTH=3: decode fields, full/empty flags,
// ordering with pointer wrap, flush priority and mid-stream reset.
module tb_ir_fetch_queue;

    localparam int DEPTH  = 3;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_instr = '0;
    logic [ADDR_W-1:0] in_pc = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       instruction_word;
    logic [5:0]        instruction_opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func_code;
    logic [15:0]       alu_immediate;
    logic [31:0]       imm_sext;
    logic [25:0]       jump_target;
    logic [1:0]        instr_class;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    ir_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_instr           (in_instr),
        .in_pc              (in_pc),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_pc             (out_pc),
        .instruction_word   (instruction_word),
        .instruction_opcode (instruction_opcode),
        .rs                 (rs),
        .rt                 (rt),
        .rd                 (rd),
        .shamt              (shamt),
        .func_code          (func_code),
        .alu_immediate      (alu_immediate),
        .imm_sext           (imm_sext),
        .jump_target        (jump_target),
        .instr_class        (instr_class),
        .count              (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle; inputs are changed and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if ({rs, rt, rd} !== 15'd0) begin failures++; $display("FAIL rst_regs got=%h exp=0", {rs, rt, rd}); end
        checks++; if (func_code !== 6'd0) begin failures++; $display("FAIL rst_func got=%h exp=0", func_code); end
        checks++; if (imm_sext !== 32'd0) begin failures++; $display("FAIL rst_imm_sext got=%h exp=0", imm_sext); end
        checks++; if (instruction_word !== 32'd0 || out_pc !== 32'd0) begin failures++; $display("FAIL rst_word_pc got=%h/%h exp=0/0", instruction_word, out_pc); end
    endtask

    task automatic test_decode();
        // add $8,$9,$10 into an empty queue: visible one cycle later
        in_valid = 1'b1; in_instr = 32'h012A4020; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL add_pc got=%h exp=100", out_pc); end
        checks++; if (rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd8) begin failures++; $display("FAIL add_regs got=%0d,%0d,%0d exp=9,10,8", rs, rt, rd); end
        checks++; if (func_code !== 6'h20 || shamt !== 5'd0 || instruction_opcode !== 6'd0) begin failures++; $display("FAIL add_func got=%h shamt=%0d op=%h exp=20,0,0", func_code, shamt, instruction_opcode); end
        checks++; if (instr_class !== 2'd0) begin failures++; $display("FAIL add_class got=%0d exp=0", instr_class); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL add_pop got=count%0d/valid%0b exp=0/0", count, out_valid); end

        // addi $8,$8,-1
        in_valid = 1'b1; in_instr = 32'h2108FFFF; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        checks++; if (instr_class !== 2'd1) begin failures++; $display("FAIL addi_class got=%0d exp=1", instr_class); end
        checks++; if (alu_immediate !== 16'hFFFF) begin failures++; $display("FAIL addi_imm got=%h exp=ffff", alu_immediate); end
        checks++; if (imm_sext !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_sext got=%h exp=ffffffff", imm_sext); end
        checks++; if (rs !== 5'd8 || rt !== 5'd8 || instruction_opcode !== 6'h08) begin failures++; $display("FAIL addi_fields got=%0d,%0d op=%h exp=8,8,08", rs, rt, instruction_opcode); end

        // push+pop at count==1: head advances to the jal, count stays 1
        in_valid = 1'b1; in_instr = 32'h0C000040; in_pc = 32'h108; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL pp1_count got=%0d exp=1", count); end
        checks++; if (out_pc !== 32'h108 || instruction_word !== 32'h0C000040) begin failures++; $display("FAIL pp1_head got=%h/%h exp=108/0c000040", out_pc, instruction_word); end
        checks++; if (instr_class !== 2'd2) begin failures++; $display("FAIL jal_class got=%0d exp=2", instr_class); end
        checks++; if (jump_target !== 26'h40) begin failures++; $display("FAIL jal_target got=%h exp=40", jump_target); end
        checks++; if (imm_sext !== 32'h00000040) begin failures++; $display("FAIL jal_sext got=%h exp=40", imm_sext); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL jal_pop got=%0d exp=0", count); end
    endtask

    task automatic test_full_and_order();
        logic [31:0] words [4];
        logic [63:0] head;
        words[0] = 32'h012A4020; words[1] = 32'h2108FFFF;
        words[2] = 32'h0C000040; words[3] = 32'h08000123;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = words[i]; in_pc = 32'h200 + 32'(4 * i);
            step();
            if (i < 3) exp_q.push_back({32'h200 + 32'(4 * i), words[i]});
            if (i == 1) begin
                checks++; if (in_ready !== 1'b1 || count !== 2'd2) begin failures++; $display("FAIL fill2 got=rdy%0b/count%0d exp=1/2", in_ready, count); end
            end
            if (i >= 2) begin
                checks++; if (in_ready !== 1'b0 || count !== 2'd3) begin failures++; $display("FAIL full%0d got=rdy%0b/count%0d exp=0/3", i, in_ready, count); end
            end
        end
        head = exp_q[0];
        checks++; if ({out_pc, instruction_word} !== head) begin failures++; $display("FAIL full_head got=%h exp=%h", {out_pc, instruction_word}, head); end

        // pop while full with the 4th word still offered: only the pop happens
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        head = exp_q[0];
        checks++; if (count !== 2'd2 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop got=count%0d/rdy%0b exp=2/1", count, in_ready); end
        checks++; if ({out_pc, instruction_word} !== head) begin failures++; $display("FAIL drain0 got=%h exp=%h", {out_pc, instruction_word}, head); end
        while (exp_q.size() > 0) begin
            step();
            void'(exp_q.pop_front());
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                checks++; if ({out_pc, instruction_word} !== head) begin failures++; $display("FAIL drain got=%h exp=%h", {out_pc, instruction_word}, head); end
            end else begin
                checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL drain_empty got=valid%0b/count%0d exp=0/0", out_valid, count); end
            end
        end
        out_ready = 1'b0;

        // Streaming push+pop across the wrap point
        in_valid = 1'b1; in_instr = 32'hA0000000; in_pc = 32'h300;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_instr = 32'hA0000000 + 32'(i); in_pc = 32'h300 + 32'(4 * i);
            step();
            checks++; if (count !== 2'd1 || out_pc !== 32'h300 + 32'(4 * i) || instruction_word !== 32'hA0000000 + 32'(i)) begin
                failures++; $display("FAIL stream%0d got=count%0d pc=%h w=%h exp=1 %h %h", i, count, out_pc, instruction_word, 32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL stream_end got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'h01095020; in_pc = 32'h400;
        step();
        in_instr = 32'h3C01ABCD; in_pc = 32'h404;
        step();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre got=%0d exp=2", count); end
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h8C220008; in_pc = 32'h408;
        step();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_state got=count%0d/valid%0b/rdy%0b exp=0/0/1", count, out_valid, in_ready); end
        checks++; if (instruction_word !== 32'd0 || rs !== 5'd0 || func_code !== 6'd0 || imm_sext !== 32'd0) begin failures++; $display("FAIL flush_nop got=%h exp=0", instruction_word); end
        in_valid = 1'b1; in_instr = 32'hAC430010; in_pc = 32'h500;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || count !== 2'd1 || out_pc !== 32'h500 || instruction_word !== 32'hAC430010) begin
            failures++; $display("FAIL flush_after got=valid%0b count%0d pc=%h w=%h exp=1 1 500 ac430010", out_valid, count, out_pc, instruction_word);
        end
        checks++; if (rs !== 5'd2 || rt !== 5'd3 || imm_sext !== 32'h10) begin failures++; $display("FAIL flush_after_fields got=%0d,%0d,%h exp=2,3,10", rs, rt, imm_sext); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_instr = 32'h00851820; in_pc = 32'h600;
        step();
        in_instr = 32'h24A5FFFE; in_pc = 32'h604;
        step();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL mrst_pre got=%0d exp=2", count); end
        reset = 1'b1; out_ready = 1'b1; in_instr = 32'h00000000; in_pc = 32'h608;
        step();
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mrst_state got=count%0d/valid%0b/rdy%0b exp=0/0/1", count, out_valid, in_ready); end
        in_valid = 1'b1; in_instr = 32'h24A5FFFE; in_pc = 32'h700;
        step();
        in_valid = 1'b0;
        checks++; if (out_pc !== 32'h700 || imm_sext !== 32'hFFFFFFFE || count !== 2'd1) begin failures++; $display("FAIL mrst_after got=pc%h sext%h count%0d exp=700 fffffffe 1", out_pc, imm_sext, count); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_full_and_order();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_fetch_queue.md
Name: ir_fetch_queue

Overview:
- Registered, parametrised instruction register for the MIPS core's bus-fetch interface.
- Buffers up to DEPTH fetched words with their PCs in a FIFO, so bus fetches and decode stalls are decoupled.
- Exposes the head entry already split into MIPS fields, plus a sign-extended immediate and an R/I/J instruction class.
- Sits between the memory-bus fetch logic and the decode/control unit.

Parameters:
- DEPTH, 2: number of queued instructions; any integer >= 2, not required to be a power of two.
- ADDR_W, 32: PC width.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries (branch/jump redirect).
- in_valid  in  1  fetched word present on in_instr/in_pc.
- in_instr  in  32  fetched instruction word.
- in_pc  in  ADDR_W  address of in_instr.
- in_ready  out  1  queue can accept a word this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head this cycle.
- out_pc  out  ADDR_W  PC of head.
- instruction_word  out  32  head instruction.
- instruction_opcode  out  6  bits [31:26].
- rs  out  5  bits [25:21].
- rt  out  5  bits [20:16].
- rd  out  5  bits [15:11].
- shamt  out  5  bits [10:6].
- func_code  out  6  bits [5:0]; always driven, regardless of opcode.
- alu_immediate  out  16  bits [15:0].
- imm_sext  out  32  alu_immediate sign-extended.
- jump_target  out  26  bits [25:0].
- instr_class  out  2  0 = R (opcode 0), 2 = J (opcode 2 or 3), 1 = I (all other opcodes).
- count  out  CNT_W  number of valid entries.

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high.
  - Clears the write pointer, read pointer and count.
  - After reset: out_valid=0, in_ready=1, count=0, all decoded outputs 0.
  - Reset during active traffic drops all entries and any same-cycle push or pop.
- Push: occurs when in_valid && in_ready.
  - Entry {in_pc, in_instr} is written at the write pointer.
  - The write pointer increments, wrapping DEPTH-1 -> 0.
- Pop: occurs when out_valid && out_ready.
  - The read pointer increments with the same wrap rule.
- Flag and count rules:
  - in_ready = (count != DEPTH). There is no pass-through when full, so a simultaneous pop does not raise in_ready in the same cycle.
  - out_valid = (count != 0).
  - count: +1 on push only, -1 on pop only, unchanged on push+pop together.
- Latency: a word pushed into an empty queue appears at the outputs in the next cycle (one-cycle latency).
- Output timing:
  - Decoded outputs are combinational from the storage entry at the read pointer; no decode logic sits on the input path.
  - When out_valid=0, all decoded outputs, out_pc and instruction_word read 0 (a NOP).
- Flush: takes priority over push and pop in the same cycle.
  - Next cycle: count=0, both pointers 0, out_valid=0.
  - The push presented in the flush cycle is dropped.
  - flush together with reset is equivalent to reset.
- Push+pop when count==1: the head advances to the new word and count stays 1.
- Push+pop when empty: impossible, since out_valid=0; only the push takes effect.
- Field extraction:
  - Pure bit-slicing.
  - imm_sext = {{16{instr[15]}}, instr[15:0]}.
- Storage contents are not cleared on reset or flush; only the pointers and count are. Verification must not check stale storage.

Decomposition:
- Package ir_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03;
  - instr_class_t enum {CLASS_R=2'd0, CLASS_I=2'd1, CLASS_J=2'd2};
  - field bit-position localparams.
- Sub-module ir_field_decode: purely combinational.
  - Input: a 32-bit word plus a valid bit.
  - Output: all field ports, instr_class and imm_sext, zero-forced when invalid.
  - Instantiated once on the head entry.
  - Reusable by later pipeline stages.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, rs/rt/rd/func_code/imm_sext all 0.
- Push 0x012A4020 (add $8,$9,$10) at pc 0x100 into empty queue -> next cycle:
  - out_valid=1, out_pc=0x100, rs=9, rt=10, rd=8, func_code=0x20, instr_class=R.
- Push 0x2108FFFF (addi $8,$8,-1) -> instr_class=I, alu_immediate=0xFFFF, imm_sext=0xFFFFFFFF; push 0x0C000040 (jal) -> instr_class=J, jump_target=0x40.
- DEPTH=3, out_ready=0:
  - push 4 words back-to-back -> in_ready falls after the 3rd and count=3; the 4th is not accepted.
  - Raise out_ready -> words pop in push order with pointer wrap; after 5 push/pop cycles order is still preserved.
- count=2 with push, pop and flush all asserted in the same cycle -> next cycle count=0, out_valid=0, decoded outputs 0; subsequent push is visible the cycle after.
- Assert reset for one cycle mid-stream with count=2 -> next cycle count=0, out_valid=0, in_ready=1.
